// File: rtl/gpr_xfer_ctrl_pkg.sv
// Shared definitions for the GPR transfer controller: FSM encodings, index types and the
// round-robin pick between the two requesters.
package gpr_xfer_ctrl_pkg;

  localparam int unsigned GPR_IDX_W = 2;
  localparam int unsigned GPR_COUNT = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Transfer captured at grant time; held until the transfer retires.
  typedef struct packed {
    req_id_e  owner;
    gpr_idx_t src;
    gpr_idx_t dst;
  } xfer_t;

  // On a tie the requester that was not served last wins.
  function automatic req_id_e rr_pick(input logic req_a, input logic req_b, input req_id_e last);
    if (req_a && req_b) begin
      return (last == REQ_A) ? REQ_B : REQ_A;
    end
    return req_a ? REQ_A : REQ_B;
  endfunction

endpackage

// File: rtl/gpr_sel_decode.sv
// Index-to-one-hot decoder with enable; drives either the GPR output enables or load strobes.
module gpr_sel_decode
  import gpr_xfer_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 4
) (
  input  logic            en_i,
  input  gpr_idx_t        sel_i,
  output logic [NREG-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/gpr_xfer_ctrl.sv
// Round-robin sequencer for register-to-register transfers over the shared GPR bus.
// Optional completed-transfer counter enabled by defining GPR_XFER_COUNT_EN.
module gpr_xfer_ctrl
  import gpr_xfer_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NREG          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [1:0] src_a,
  input  logic [1:0] dst_a,
  input  logic       req_b,
  input  logic [1:0] src_b,
  input  logic [1:0] dst_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic       busy,
  output logic       e_r0,
  output logic       e_r1,
  output logic       e_r2,
  output logic       e_r3,
  output logic       s_r0,
  output logic       s_r1,
  output logic       s_r2,
  output logic       s_r3,
  output logic [7:0] xfer_count
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  xfer_t           cur_q, cur_d;
  req_id_e         last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            gnt_a_q, gnt_a_d;
  logic            gnt_b_q, gnt_b_d;
  logic            done_a_q, done_a_d;
  logic            done_b_q, done_b_d;
  logic            busy_q, busy_d;
  logic [NREG-1:0] e_q, e_d;
  logic [NREG-1:0] s_q, s_d;
  logic            e_en, s_en;
  req_id_e         pick;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pick    = rr_pick(req_a, req_b, last_q);
    case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          cur_d.owner = pick;
          cur_d.src   = (pick == REQ_A) ? src_a : src_b;
          cur_d.dst   = (pick == REQ_A) ? dst_a : dst_b;
          last_d      = pick;
          cnt_d       = SettleLoad;
          // A self-transfer has nothing to move; retire it straight away.
          state_d     = (cur_d.src == cur_d.dst) ? ST_RELEASE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_LOAD:    state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every one of them leaves a flop.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    gnt_a_d  = busy_d && (cur_d.owner == REQ_A);
    gnt_b_d  = busy_d && (cur_d.owner == REQ_B);
    done_a_d = (state_d == ST_RELEASE) && (cur_d.owner == REQ_A);
    done_b_d = (state_d == ST_RELEASE) && (cur_d.owner == REQ_B);
    e_en     = (state_d == ST_DRIVE) || (state_d == ST_LOAD);
    s_en     = (state_d == ST_LOAD);
  end

  gpr_sel_decode #(
    .NREG (NREG)
  ) u_src_dec (
    .en_i     (e_en),
    .sel_i    (cur_d.src),
    .onehot_o (e_d)
  );

  gpr_sel_decode #(
    .NREG (NREG)
  ) u_dst_dec (
    .en_i     (s_en),
    .sel_i    (cur_d.dst),
    .onehot_o (s_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      last_q   <= REQ_B;
      cnt_q    <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q   <= 1'b0;
      e_q      <= '0;
      s_q      <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      busy_q   <= busy_d;
      e_q      <= e_d;
      s_q      <= s_d;
    end
  end

  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign done_a = done_a_q;
  assign done_b = done_b_q;
  assign busy   = busy_q;
  assign e_r0   = e_q[0];
  assign e_r1   = e_q[1];
  assign e_r2   = e_q[2];
  assign e_r3   = e_q[3];
  assign s_r0   = s_q[0];
  assign s_r1   = s_q[1];
  assign s_r2   = s_q[2];
  assign s_r3   = s_q[3];

`ifdef GPR_XFER_COUNT_EN
  logic [7:0] xfer_count_q, xfer_count_d;

  // Counts each retiring transfer, self-transfers included; wraps naturally at 8 bits.
  always_comb begin
    xfer_count_d = xfer_count_q;
    if (state_q == ST_RELEASE) begin
      xfer_count_d = xfer_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_count_q <= 8'h00;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`else
  assign xfer_count = 8'h00;
`endif

endmodule
